// File: rtl/cam_frame_writer_if.sv
// cam_frame_writer_if: camera byte stream in, frame-buffer write beats out
interface cam_frame_writer_if #(
    parameter int ADDR_BITS = 20
);
    logic                 cam_vsync;
    logic                 cam_href;
    logic [7:0]           cam_data;
    logic                 wr_en;
    logic [15:0]          wr_data;
    logic [ADDR_BITS-1:0] wr_addr;
    modport master (input cam_vsync, cam_href, cam_data, output wr_en, wr_data, wr_addr);
    modport slave (output cam_vsync, cam_href, cam_data, input wr_en, wr_data, wr_addr);
endinterface

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: DVP byte stream to RGB565 frame-buffer writes with frame validation
module cam_frame_writer #(
    parameter int H_RES     = 1280,
    parameter int V_RES     = 720,
    parameter int ADDR_BITS = 20,
    parameter int HI_FIRST  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    cam_frame_writer_if.master bus,
    output logic               frame_buffer_ready,
    output logic               frame_done,
    output logic               frame_err
);
    localparam int XW = $clog2(H_RES + 2);
    localparam int YW = $clog2(V_RES + 2);
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;
    state_t               state;
    logic                 vs_d, hr_d, phase, err;
    logic [7:0]           byte_q;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [ADDR_BITS-1:0] line_base;
    logic                 vs_rise, vs_fall, line_end, err_n;
    logic [YW-1:0]        y_n;
    // Edges plus the error/line state as seen after a line ending in this same cycle
    always_comb begin
        vs_rise  = bus.cam_vsync & ~vs_d;
        vs_fall  = ~bus.cam_vsync & vs_d;
        line_end = (hr_d & ~bus.cam_href) | (vs_rise & bus.cam_href);
        err_n    = err | (line_end & ((x != XW'(H_RES)) | phase));
        y_n      = (line_end && y != YW'(V_RES + 1)) ? y + 1'b1 : y;
    end
    // Capture FSM: byte pairing, address generation and frame-end verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            vs_d               <= 1'b0;
            hr_d               <= 1'b0;
            phase              <= 1'b0;
            err                <= 1'b0;
            byte_q             <= '0;
            x                  <= '0;
            y                  <= '0;
            line_base          <= '0;
            bus.wr_en          <= 1'b0;
            bus.wr_data        <= '0;
            bus.wr_addr        <= '0;
            frame_buffer_ready <= 1'b0;
            frame_done         <= 1'b0;
            frame_err          <= 1'b0;
        end else begin
            bus.wr_en  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            vs_d       <= bus.cam_vsync;
            hr_d       <= bus.cam_href;
            case (state)
                IDLE: if (enable) state <= WAIT_VS;
                WAIT_VS: begin
                    if (!enable) state <= IDLE;
                    else if (vs_fall) begin
                        state     <= ACTIVE;
                        x         <= '0;
                        y         <= '0;
                        line_base <= '0;
                        phase     <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (line_end) begin
                        err   <= err_n;
                        y     <= y_n;
                        x     <= '0;
                        phase <= 1'b0;
                        if (y < YW'(V_RES)) line_base <= line_base + ADDR_BITS'(H_RES);
                    end else if (bus.cam_href) begin
                        if (!phase) begin
                            byte_q <= bus.cam_data;
                            phase  <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (x != XW'(H_RES + 1)) x <= x + 1'b1;
                            if (x < XW'(H_RES) && y < YW'(V_RES)) begin
                                bus.wr_en   <= 1'b1;
                                bus.wr_data <= (HI_FIRST != 0) ? {byte_q, bus.cam_data} : {bus.cam_data, byte_q};
                                bus.wr_addr <= line_base + ADDR_BITS'(x);
                            end
                        end
                    end
                    if (vs_rise) begin
                        state <= WAIT_VS;
                        if (!err_n && y_n == YW'(V_RES)) begin
                            frame_done         <= 1'b1;
                            frame_buffer_ready <= 1'b1;
                        end else frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: directed and random frames against a frame-level reference model
module tb_cam_frame_writer;
    localparam int H = 4;
    localparam int V = 3;
    localparam int AB = 20;
    logic clk = 1'b0;
    logic rst_n, enable, vs, hr;
    logic [7:0] dat;
    logic rdy1, done1, err1, rdy0, done0, err0;
    cam_frame_writer_if #(.ADDR_BITS(AB)) w1 ();
    cam_frame_writer_if #(.ADDR_BITS(AB)) w0 ();
    assign w1.cam_vsync = vs;
    assign w1.cam_href  = hr;
    assign w1.cam_data  = dat;
    assign w0.cam_vsync = vs;
    assign w0.cam_href  = hr;
    assign w0.cam_data  = dat;
    cam_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_BITS(AB), .HI_FIRST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(w1),
        .frame_buffer_ready(rdy1), .frame_done(done1), .frame_err(err1));
    cam_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_BITS(AB), .HI_FIRST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(w0),
        .frame_buffer_ready(rdy0), .frame_done(done0), .frame_err(err0));
    always #5 clk = ~clk;
    logic [35:0] act1[$], act0[$];
    int d1 = 0, e1 = 0, d0 = 0, e0 = 0;
    int errors = 0, checks = 0;
    bit ready_exp = 1'b0;
    int lens[$];
    logic [7:0] bb[6][16];
    // Collect every write beat and pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (w1.wr_en) act1.push_back({w1.wr_addr, w1.wr_data});
        if (w0.wr_en) act0.push_back({w0.wr_addr, w0.wr_data});
        d1 = d1 + int'(done1);
        e1 = e1 + int'(err1);
        d0 = d0 + int'(done0);
        e0 = e0 + int'(err0);
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_u1"}, {w1.wr_en, w1.wr_data, w1.wr_addr, rdy1, done1, err1}, 64'd0);
        chk({tag, "_u0"}, {w0.wr_en, w0.wr_data, w0.wr_addr, rdy0, done0, err0}, 64'd0);
    endtask
    // One frame: lens[] gives bytes per line; en0 is enable at the vsync fall,
    // en_line raises enable at that line, rst_at pulses rst_n on that byte index
    task automatic run_frame(input bit pat, input bit en0, input int en_line, input int rst_at);
        int gi = 0;
        int g = 0;
        bit good;
        bit done_exp, err_exp;
        logic [35:0] e1q[$], e0q[$];
        act1.delete();
        act0.delete();
        d1 = 0; e1 = 0; d0 = 0; e0 = 0;
        @(negedge clk);
        vs = 1'b1;
        enable = en0;
        repeat (3) @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < lens.size(); l++) begin
            if (l == en_line) enable = 1'b1;
            for (int i = 0; i < lens[l]; i++) begin
                hr = 1'b1;
                dat = pat ? 8'(32'h12 + 32'h22 * gi) : 8'($urandom);
                bb[l][i] = dat;
                if (gi == rst_at) rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                if (gi == rst_at) chk_zero("mid_reset");
                gi++;
            end
            hr = 1'b0;
            repeat (3) @(negedge clk);
        end
        vs = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        good = (lens.size() == V);
        for (int l = 0; l < lens.size(); l++) begin
            if (lens[l] != 2 * H) good = 1'b0;
            for (int p = 0; 2 * p + 1 < lens[l]; p++)
                if (en0 && l < V && p < H && (rst_at < 0 || g + 2 * p + 1 < rst_at)) begin
                    e1q.push_back({20'(l * H + p), bb[l][2*p], bb[l][2*p+1]});
                    e0q.push_back({20'(l * H + p), bb[l][2*p+1], bb[l][2*p]});
                end
            g += lens[l];
        end
        done_exp = en0 && rst_at < 0 && good;
        err_exp = en0 && rst_at < 0 && !good;
        if (rst_at >= 0) ready_exp = 1'b0;
        ready_exp = ready_exp | done_exp;
        chk("wr_count_u1", act1.size(), e1q.size());
        chk("wr_count_u0", act0.size(), e0q.size());
        for (int i = 0; i < act1.size() && i < e1q.size(); i++) chk($sformatf("wr_u1[%0d]", i), act1[i], e1q[i]);
        for (int i = 0; i < act0.size() && i < e0q.size(); i++) chk($sformatf("wr_u0[%0d]", i), act0[i], e0q[i]);
        chk("done_cycles_u1", d1, done_exp);
        chk("err_cycles_u1", e1, err_exp);
        chk("done_cycles_u0", d0, done_exp);
        chk("err_cycles_u0", e0, err_exp);
        chk("ready_u1", rdy1, ready_exp);
        chk("ready_u0", rdy0, ready_exp);
    endtask
    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        vs = 1'b1;
        hr = 1'b0;
        dat = 8'h00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        enable = 1'b1;
        lens = '{8, 12, 8};
        run_frame(1'b0, 1'b1, -1, -1);
        lens = '{9, 8, 8};
        run_frame(1'b0, 1'b1, -1, -1);
        lens = '{8, 8};
        run_frame(1'b0, 1'b1, -1, -1);
        lens = '{8, 8, 8};
        run_frame(1'b1, 1'b1, -1, -1);
        chk("t1_first_u1", act1.size() > 0 ? act1[0] : 36'hx, {20'd0, 16'h1234});
        chk("t1_first_u0", act0.size() > 0 ? act0[0] : 36'hx, {20'd0, 16'h3412});
        chk("t1_last_u1", act1.size() > 0 ? act1[act1.size()-1] : 36'hx, {20'd11, 16'hFE20});
        run_frame(1'b0, 1'b0, 1, -1);
        run_frame(1'b0, 1'b1, -1, -1);
        lens = '{8, 8, 8};
        run_frame(1'b0, 1'b1, -1, 10);
        run_frame(1'b1, 1'b1, -1, -1);
        for (int k = 0; k < 8; k++) begin
            int nl;
            nl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 4)) : 3;
            lens.delete();
            for (int l = 0; l < nl; l++)
                lens.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : 8);
            run_frame(1'b0, 1'b1, -1, -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
